// File: rtl/ps2_key_sequencer_if.sv
// Scan-byte, lookup and FIFO-read signals of the PS/2 key sequencer.
// The sequencer takes the slave side; the receiver, lookup ROM and consumer take the master side.
interface ps2_key_sequencer_if #(
    parameter int ADDR_W = 3
);
    logic              scan_valid;
    logic [7:0]        scan_code;
    logic [7:0]        lookup_code;
    logic [7:0]        lookup_ascii;
    logic              rd_en;
    logic [7:0]        rd_data;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              clr_err;

    modport master (
        output scan_valid, scan_code, lookup_ascii, rd_en, clr_err,
        input  lookup_code, rd_data, empty, full, count, overflow
    );

    modport slave (
        input  scan_valid, scan_code, lookup_ascii, rd_en, clr_err,
        output lookup_code, rd_data, empty, full, count, overflow
    );
endinterface

// File: rtl/ps2_key_sequencer.sv
// Parses PS/2 make/break/extended bytes, drives the ASCII lookup, suppresses
// typematic repeats and queues the resulting characters in a show-ahead FIFO.
module ps2_key_sequencer #(
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int REPEAT_EN = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    ps2_key_sequencer_if.slave   bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] BRK     = 3'd1;
    localparam logic [2:0] EXT     = 3'd2;
    localparam logic [2:0] EXT_BRK = 3'd3;
    localparam logic [2:0] LOOKUP  = 3'd4;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [2:0]        state;
    logic [7:0]        lookup_code_q;
    logic [7:0]        held;
    logic              held_valid;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              overflow_q;

    logic is_empty, is_full, suppress, enq_req, do_push, do_pop, drop, late_byte;

    assign is_empty  = (count_q == '0);
    assign is_full   = (count_q == FULL_COUNT);
    assign suppress  = (REPEAT_EN == 0) && held_valid && (lookup_code_q == held);
    assign enq_req   = (state == LOOKUP) && (bus.lookup_ascii != 8'h00) && !suppress;
    // A pop on an empty FIFO is ignored, which also makes push-on-empty win over rd_en.
    assign do_pop    = bus.rd_en && !is_empty;
    assign do_push   = enq_req && (!is_full || do_pop);
    assign drop      = enq_req && is_full && !do_pop;
    assign late_byte = (state == LOOKUP) && bus.scan_valid;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            lookup_code_q <= 8'h00;
            held          <= 8'h00;
            held_valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.scan_valid) begin
                    if (bus.scan_code == 8'hF0)      state <= BRK;
                    else if (bus.scan_code == 8'hE0) state <= EXT;
                    else begin
                        lookup_code_q <= bus.scan_code;
                        state         <= LOOKUP;
                    end
                end
                BRK: if (bus.scan_valid) begin
                    if (bus.scan_code == held) held_valid <= 1'b0;
                    state <= IDLE;
                end
                EXT: if (bus.scan_valid) begin
                    state <= (bus.scan_code == 8'hF0) ? EXT_BRK : IDLE;
                end
                EXT_BRK: if (bus.scan_valid) state <= IDLE;
                LOOKUP: begin
                    state <= IDLE;
                    if (bus.lookup_ascii != 8'h00) begin
                        held       <= lookup_code_q;
                        held_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
            if (drop || late_byte) overflow_q <= 1'b1;
            else if (bus.clr_err)  overflow_q <= 1'b0;
        end
    end

    // NOTE: storage is not reset; resetting the pointers and count already makes old entries unreachable.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= bus.lookup_ascii;
    end

    assign bus.lookup_code = lookup_code_q;
    assign bus.rd_data     = is_empty ? 8'h00 : mem[rd_ptr];
    assign bus.empty       = is_empty;
    assign bus.full        = is_full;
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench: two sequencers (repeat suppressed / repeat enabled) fed the same byte stream.
module tb_ps2_key_sequencer;
    logic       clock;
    logic       reset;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       rd_en;
    logic       clr_err;

    int n_cmp  = 0;
    int n_fail = 0;

    ps2_key_sequencer_if #(.ADDR_W(3)) bus0 ();
    ps2_key_sequencer_if #(.ADDR_W(3)) bus1 ();

    ps2_key_sequencer #(.DEPTH(8), .ADDR_W(3), .REPEAT_EN(0)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0)
    );
    ps2_key_sequencer #(.DEPTH(8), .ADDR_W(3), .REPEAT_EN(1)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1)
    );

    function automatic logic [7:0] ascii_of(input logic [7:0] code);
        case (code)
            8'h1C: ascii_of = 8'h41;
            8'h32: ascii_of = 8'h42;
            8'h21: ascii_of = 8'h43;
            8'h23: ascii_of = 8'h44;
            8'h24: ascii_of = 8'h45;
            8'h2B: ascii_of = 8'h46;
            8'h34: ascii_of = 8'h47;
            8'h33: ascii_of = 8'h48;
            8'h43: ascii_of = 8'h49;
            8'h29: ascii_of = 8'h20;
            8'h75: ascii_of = 8'h38;
            default: ascii_of = 8'h00;
        endcase
    endfunction

    assign bus0.scan_valid   = scan_valid;
    assign bus0.scan_code    = scan_code;
    assign bus0.rd_en        = rd_en;
    assign bus0.clr_err      = clr_err;
    assign bus0.lookup_ascii = ascii_of(bus0.lookup_code);
    assign bus1.scan_valid   = scan_valid;
    assign bus1.scan_code    = scan_code;
    assign bus1.rd_en        = rd_en;
    assign bus1.clr_err      = clr_err;
    assign bus1.lookup_ascii = ascii_of(bus1.lookup_code);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] code;
        int         cnt0;
        int         cnt1;
        logic [7:0] lc0;
    } vec_t;

    vec_t vecs [18];
    logic [7:0] keys [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    logic [7:0] drain0 [6] = '{8'h41, 8'h41, 8'h20, 8'h00, 8'h00, 8'h00};
    logic [7:0] drain1 [6] = '{8'h41, 8'h41, 8'h41, 8'h41, 8'h20, 8'h20};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        scan_valid = 1'b1;
        scan_code  = b;
        tick();
        scan_valid = 1'b0;
        tick();
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic fill8();
        for (int i = 0; i < 8; i++) begin
            send(keys[i]);
            send(8'hF0);
            send(keys[i]);
        end
    endtask

    initial begin
        reset = 1'b1; scan_valid = 1'b0; scan_code = 8'h00; rd_en = 1'b0; clr_err = 1'b0;
        vecs[0]  = '{8'h1C, 1, 1, 8'h1C};
        vecs[1]  = '{8'h1C, 1, 2, 8'h1C};
        vecs[2]  = '{8'h1C, 1, 3, 8'h1C};
        vecs[3]  = '{8'hF0, 1, 3, 8'h1C};
        vecs[4]  = '{8'h1C, 1, 3, 8'h1C};
        vecs[5]  = '{8'h1C, 2, 4, 8'h1C};
        vecs[6]  = '{8'hF0, 2, 4, 8'h1C};
        vecs[7]  = '{8'h1C, 2, 4, 8'h1C};
        vecs[8]  = '{8'hE0, 2, 4, 8'h1C};
        vecs[9]  = '{8'h75, 2, 4, 8'h1C};
        vecs[10] = '{8'hE0, 2, 4, 8'h1C};
        vecs[11] = '{8'hF0, 2, 4, 8'h1C};
        vecs[12] = '{8'h75, 2, 4, 8'h1C};
        vecs[13] = '{8'h29, 3, 5, 8'h29};
        vecs[14] = '{8'h05, 3, 5, 8'h05};
        vecs[15] = '{8'h29, 3, 6, 8'h29};
        vecs[16] = '{8'hF0, 3, 6, 8'h29};
        vecs[17] = '{8'h29, 3, 6, 8'h29};

        tick();
        do_reset();
        check("rst_lookup_code", bus0.lookup_code, 8'h00);
        check("rst_count", bus0.count, 0);
        check("rst_empty", bus0.empty, 1);
        check("rst_full", bus0.full, 0);
        check("rst_rd_data", bus0.rd_data, 8'h00);
        check("rst_overflow", bus0.overflow, 0);

        // Single key: latency and pop
        scan_valid = 1'b1; scan_code = 8'h1C;
        tick();
        scan_valid = 1'b0;
        check("lat_lookup_code", bus0.lookup_code, 8'h1C);
        check("lat_empty_n1", bus0.empty, 1);
        tick();
        check("lat_rd_data", bus0.rd_data, 8'h41);
        check("lat_count", bus0.count, 1);
        pop();
        check("pop_empty", bus0.empty, 1);
        check("pop_rd_data", bus0.rd_data, 8'h00);

        // Typematic / break / extended table
        do_reset();
        for (int i = 0; i < 18; i++) begin
            send(vecs[i].code);
            check($sformatf("vec%0d_count0", i), bus0.count, vecs[i].cnt0);
            check($sformatf("vec%0d_count1", i), bus1.count, vecs[i].cnt1);
            check($sformatf("vec%0d_lookup0", i), bus0.lookup_code, vecs[i].lc0);
            check($sformatf("vec%0d_head0", i), bus0.rd_data, 8'h41);
        end
        for (int i = 0; i < 6; i++) begin
            check($sformatf("drain%0d_data0", i), bus0.rd_data, drain0[i]);
            check($sformatf("drain%0d_data1", i), bus1.rd_data, drain1[i]);
            pop();
        end
        check("drain_count0", bus0.count, 0);
        check("drain_count1", bus1.count, 0);
        check("drain_overflow0", bus0.overflow, 0);

        // Fill and overflow by a ninth key
        do_reset();
        fill8();
        check("fill_full", bus0.full, 1);
        check("fill_count", bus0.count, 8);
        check("fill_overflow_pre", bus0.overflow, 0);
        send(keys[8]);
        check("ovf_full", bus0.full, 1);
        check("ovf_count", bus0.count, 8);
        check("ovf_overflow", bus0.overflow, 1);
        check("ovf_head", bus0.rd_data, 8'h41);

        // Ninth key with a pop in its LOOKUP cycle
        do_reset();
        fill8();
        scan_valid = 1'b1; scan_code = keys[8];
        tick();
        scan_valid = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("simul_overflow", bus0.overflow, 0);
        check("simul_count", bus0.count, 8);
        check("simul_full", bus0.full, 1);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("simul_head%0d", i), bus0.rd_data, 8'h42 + i);
            pop();
        end
        check("simul_tail", bus0.rd_data, 8'h49);
        check("simul_tail_count", bus0.count, 1);

        // Byte during LOOKUP is dropped
        do_reset();
        scan_valid = 1'b1; scan_code = 8'h1C;
        tick();
        scan_code = 8'h32;
        tick();
        scan_valid = 1'b0;
        tick();
        check("late_count", bus0.count, 1);
        check("late_head", bus0.rd_data, 8'h41);
        check("late_overflow", bus0.overflow, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_overflow", bus0.overflow, 0);

        // Reset while in BRK with entries queued
        do_reset();
        send(8'h1C); send(8'hF0); send(8'h1C);
        send(8'h32); send(8'hF0); send(8'h32);
        send(8'h21);
        check("brk_pre_count", bus0.count, 3);
        scan_valid = 1'b1; scan_code = 8'hF0;
        tick();
        scan_valid = 1'b0;
        do_reset();
        check("brk_rst_count", bus0.count, 0);
        check("brk_rst_empty", bus0.empty, 1);
        send(8'h1C);
        check("brk_after_count", bus0.count, 1);
        check("brk_after_head", bus0.rd_data, 8'h41);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_key_sequencer.md
# ps2_key_sequencer

Sequences the PS/2 scan-code-to-ASCII lookup between the PS/2 byte receiver and the processor's keyboard port. The block parses raw scan bytes (make, F0 break prefix, E0 extended prefix), presents qualifying make codes to the external lookup, suppresses typematic repeats, and buffers the resulting ASCII characters in a show-ahead FIFO read by the consumer.

## Interface

Parameters:
- DEPTH, 8: FIFO entries; power of two, minimum 2.
- ADDR_W, 3: log2(DEPTH).
- REPEAT_EN, 0: 1 = auto-repeat make codes are enqueued; 0 = suppressed while the key is held.

Ports:
- clock  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- scan_valid  input  1  one-cycle strobe; scan_code holds a received byte.
- scan_code  input  8  raw PS/2 byte.
- lookup_code  output  8  registered code driven to the scan-to-ASCII lookup.
- lookup_ascii  input  8  combinational lookup result for lookup_code; 8'h00 = unmapped.
- rd_en  input  1  consumer pops the head entry this cycle.
- rd_data  output  8  head entry (show-ahead); 8'h00 when empty.
- empty  output  1  FIFO holds no entries.
- full  output  1  FIFO holds DEPTH entries.
- count  output  ADDR_W+1  occupancy, 0..DEPTH.
- overflow  output  1  sticky: a character was dropped (FIFO full or byte arrived during LOOKUP).
- clr_err  input  1  clears overflow.

## Operation

- FSM states: IDLE, BRK, EXT, EXT_BRK, LOOKUP.
- IDLE, scan_valid: 8'hF0 -> BRK; 8'hE0 -> EXT; any other byte -> latch into lookup_code, -> LOOKUP.
- BRK, scan_valid: if byte == held, clear held_valid; -> IDLE. No enqueue.
- EXT, scan_valid: 8'hF0 -> EXT_BRK; any other byte discarded (extended keys unmapped) -> IDLE.
- EXT_BRK, scan_valid: byte discarded -> IDLE.
- LOOKUP (exactly one cycle, unconditional -> IDLE): sample lookup_ascii. Enqueue iff lookup_ascii != 8'h00 and not (REPEAT_EN == 0 and held_valid and lookup_code == held). On any nonzero lookup_ascii, held <= lookup_code, held_valid <= 1.
- A scan_valid arriving in LOOKUP is dropped and sets overflow.
- A 8'hE0/8'hF0 byte never reaches lookup_code.
- FIFO: circular, ADDR_W-bit read/write pointers wrap DEPTH-1 -> 0; count tracks occupancy.
- Enqueue with full and no rd_en: dropped, overflow set, contents unchanged.
- Enqueue with full and rd_en same cycle: both performed, count stays DEPTH.
- Enqueue with empty and rd_en same cycle: rd_en ignored, entry written, count 0 -> 1.
- rd_en with empty: ignored.
- overflow: set dominates clr_err in the same cycle.

## Timing

- Reset values: state IDLE, lookup_code 8'h00, held_valid 0, pointers 0, count 0, empty 1, full 0, rd_data 8'h00, overflow 0.
- Reset mid-sequence (e.g. in BRK or LOOKUP) aborts the sequence; the next byte is parsed from IDLE; FIFO contents are lost.
- Latency: scan_valid at cycle N -> lookup_code valid cycle N+1 (LOOKUP) -> entry written at end of N+1 -> empty low and rd_data valid in N+2.
- State returns to IDLE at N+2; back-to-back bytes at N, N+2 are both accepted; a byte at N+1 is dropped.
- rd_data/empty/full/count are registered-state functions; a pop in cycle M shows the next entry in M+1.
- lookup_ascii must settle within one clock of lookup_code changing.

## Test plan

- Reset, then scan 8'h1C -> lookup_code 8'h1C at N+1, rd_data 8'h41, count 1 at N+2; rd_en one cycle -> empty 1, rd_data 8'h00.
- Sequence 1C, 1C, 1C, F0, 1C, 1C with REPEAT_EN=0 -> FIFO holds 8'h41, 8'h41 (count 2); REPEAT_EN=1 -> count 4.
- E0 75, E0 F0 75, then 8'h29 -> only 8'h20 enqueued; unmapped 8'h05 -> nothing enqueued, held unchanged.
- Fill with 8 distinct mapped keys (each followed by its break) then one more -> full 1, count 8, overflow 1, head still first char; repeat with rd_en in the ninth write's LOOKUP cycle -> overflow 0, count 8, ninth char at tail.
- Byte during LOOKUP (scan_valid at N and N+1) -> only first enqueued, overflow 1; clr_err pulse -> overflow 0.
- Assert reset while in BRK with 3 entries queued -> count 0, empty 1; next 8'h1C enqueues 8'h41 (not treated as a break).
